// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount out as timed one-hot coin pulses,
// largest denomination first (50/20/10/5/1).
//
// Ports:
//   sys_clk, sys_rst  clock, async active-high reset
//   start, abort      one-cycle payout request / stop request
//   change_money      amount to pay (sampled at accepted start)
//   coin_pulse        one-hot coin: b0=1 b1=5 b2=10 b3=20 b4=50
//   remaining         amount not yet dispensed
//   coin_count        coins issued in current or last payout
//   busy, done        non-idle flag, completion pulse
module change_dispenser #(
  parameter int PULSE_CYCLES = 5_000_000,
  parameter int GAP_CYCLES   = 5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] change_money,
  output logic [4:0] coin_pulse,
  output logic [7:0] remaining,
  output logic [3:0] coin_count,
  output logic       busy,
  output logic       done
);

  localparam int MAXC =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CLG = $clog2(MAXC + 1);
  localparam int CW  = (CLG > 23) ? CLG : 23;

  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] tmr;
  logic [4:0]    sel_coin;
  logic [7:0]    sel_val;

  // Greedy pick; ranges are disjoint so the decode is unique.
  always_comb begin
    sel_coin = 5'b00000;
    sel_val  = 8'd0;
    unique case (1'b1)
      (remaining >= 8'd50): begin
        sel_coin = 5'b10000;
        sel_val  = 8'd50;
      end
      (remaining >= 8'd20 && remaining < 8'd50): begin
        sel_coin = 5'b01000;
        sel_val  = 8'd20;
      end
      (remaining >= 8'd10 && remaining < 8'd20): begin
        sel_coin = 5'b00100;
        sel_val  = 8'd10;
      end
      (remaining >= 8'd5 && remaining < 8'd10): begin
        sel_coin = 5'b00010;
        sel_val  = 8'd5;
      end
      (remaining >= 8'd1 && remaining < 8'd5): begin
        sel_coin = 5'b00001;
        sel_val  = 8'd1;
      end
      default: begin
        sel_coin = 5'b00000;
        sel_val  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      tmr        <= '0;
      coin_pulse <= 5'b0;
      remaining  <= 8'd0;
      coin_count <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && state != IDLE) begin
      // remaining/coin_count stay frozen to show what was not paid
      state      <= IDLE;
      tmr        <= '0;
      coin_pulse <= 5'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          tmr  <= '0;
          if (start && !abort) begin
            remaining  <= change_money;
            coin_count <= 4'd0;
            busy       <= 1'b1;
            if (change_money != 8'd0) begin
              state <= SELECT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SELECT: begin
          coin_pulse <= sel_coin;
          remaining  <= remaining - sel_val;
          coin_count <= coin_count + 4'd1;
          tmr        <= P_LOAD;
          state      <= PULSE;
        end
        PULSE: begin
          if (tmr == '0) begin
            coin_pulse <= 5'b0;
            tmr        <= G_LOAD;
            state      <= GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GAP: begin
          if (tmr == '0) begin
            if (remaining != 8'd0) begin
              state <= SELECT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          tmr   <= '0;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          tmr        <= '0;
          coin_pulse <= 5'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser.
// Short pulse/gap timing so full payouts fit in a few cycles.
module tb_change_dispenser;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] change_money = 8'd0;
  logic [4:0] coin_pulse;
  logic [7:0] remaining;
  logic [3:0] coin_count;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  logic [4:0] exp_seq [12];

  change_dispenser #(
    .PULSE_CYCLES(2),
    .GAP_CYCLES(1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .start(start),
    .abort(abort),
    .change_money(change_money),
    .coin_pulse(coin_pulse),
    .remaining(remaining),
    .coin_count(coin_count),
    .busy(busy),
    .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int coin_val(input logic [4:0] c);
    case (c)
      5'h01:   return 1;
      5'h02:   return 5;
      5'h04:   return 10;
      5'h08:   return 20;
      5'h10:   return 50;
      default: return 0;
    endcase
  endfunction

  // Pay m and watch n expected coins from exp_seq.
  // Cycle c counts from the cycle after start is sampled.
  // mid=1 fires an ignored start with 99 during the payout.
  task automatic pay(input logic [7:0] m,
                     input int n,
                     input bit mid);
    int done_at;
    int ncoin;
    int hi;
    int rem_exp;
    logic [4:0] prev;
    done_at = -1;
    ncoin = 0;
    hi = 0;
    rem_exp = m;
    prev = 5'b0;
    start = 1'b1;
    change_money = m;
    for (int c = 1; c <= 4 * n + 4; c++) begin
      tick();
      start = 1'b0;
      if (mid && c == 5) begin
        start = 1'b1;
        change_money = 8'd99;
      end
      if (coin_pulse != 5'b0 && prev == 5'b0) begin
        if (ncoin < n) begin
          check("coin", int'(coin_pulse), int'(exp_seq[ncoin]));
          check("coin_t", c, 2 + 4 * ncoin);
          rem_exp -= coin_val(exp_seq[ncoin]);
          check("rem", int'(remaining), rem_exp);
          check("cnt", int'(coin_count), ncoin + 1);
        end
        ncoin++;
      end
      if ($countones(coin_pulse) > 1)
        check("onehot", int'(coin_pulse), 0);
      if (coin_pulse != 5'b0) begin
        hi++;
      end else if (prev != 5'b0) begin
        check("plen", hi, 2);
        hi = 0;
      end
      if (done) begin
        if (done_at < 0) done_at = c;
        else check("done_dup", c, done_at);
      end
      if (c == 4 * n + 1)
        check("busy_done", int'(busy), 1);
      prev = coin_pulse;
    end
    check("ncoin", ncoin, n);
    check("done_at", done_at, 4 * n + 1);
    check("busy_end", int'(busy), 0);
    check("rem_end", int'(remaining), 0);
    check("cnt_end", int'(coin_count), n);
  endtask

  initial begin
    #2;
    check("rst_coin", int'(coin_pulse), 0);
    check("rst_rem", int'(remaining), 0);
    check("rst_cnt", int'(coin_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    tick();
    sys_rst = 1'b0;
    tick();

    exp_seq = '{5'h08, 5'h04, 5'h02, 5'h01, 5'h01,
                5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                5'h00, 5'h00};
    pay(8'd37, 5, 1'b0);
    tick();

    pay(8'd0, 0, 1'b0);
    tick();

    exp_seq = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10,
                5'h02, 5'h00, 5'h00, 5'h00, 5'h00,
                5'h00, 5'h00};
    pay(8'd255, 6, 1'b0);
    tick();

    exp_seq = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h08,
                5'h08, 5'h02, 5'h01, 5'h01, 5'h01,
                5'h01, 5'h00};
    pay(8'd249, 11, 1'b0);
    tick();

    exp_seq = '{5'h08, 5'h04, 5'h02, 5'h01, 5'h01,
                5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                5'h00, 5'h00};
    pay(8'd37, 5, 1'b1);
    tick();

    // abort in the first cycle of the second coin's pulse
    start = 1'b1;
    change_money = 8'd37;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    check("ab_pre", int'(coin_pulse), 5'h04);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_coin", int'(coin_pulse), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_rem", int'(remaining), 7);
    check("ab_cnt", int'(coin_count), 2);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done || busy || coin_pulse != 5'b0)
        check("ab_quiet", int'({done, busy, coin_pulse}), 0);
    end
    check("ab_hold", int'(remaining), 7);

    // abort alone in idle changes nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ia_busy", int'(busy), 0);
    check("ia_rem", int'(remaining), 7);

    // async reset in the gap of the first coin
    start = 1'b1;
    change_money = 8'd37;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
    end
    check("gap_busy", int'(busy), 1);
    check("gap_rem", int'(remaining), 17);
    #2;
    sys_rst = 1'b1;
    #1;
    check("ar_coin", int'(coin_pulse), 0);
    check("ar_rem", int'(remaining), 0);
    check("ar_cnt", int'(coin_count), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_done", int'(done), 0);
    tick();
    sys_rst = 1'b0;
    tick();

    // start with abort in idle is ignored
    start = 1'b1;
    abort = 1'b1;
    change_money = 8'd37;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", int'(busy), 0);
    check("sa_rem", int'(remaining), 0);
    tick();
    check("sa_busy2", int'(busy), 0);
    check("sa_coin", int'(coin_pulse), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1);
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the vending state machine: consumes the registered change amount and the change request.
- Pays the amount out as a timed sequence of single-coin pulses using the largest denomination first (50/20/10/5/1).
- The coin bit order matches the money-input bus, so the LED/RGB stage and the bench reuse the same one-hot encoding.

Parameters:
PULSE_CYCLES, 5_000_000, cycles each coin_pulse bit is held high (>=1)
GAP_CYCLES, 5_000_000, idle cycles between coins (>=1)

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request pulse to pay change_money
abort  input  1  one-cycle request to stop paying out
change_money  input  8  amount to pay, unsigned units of 1
coin_pulse  output  5  one-hot coin out: bit0=1, bit1=5, bit2=10, bit3=20, bit4=50
remaining  output  8  amount not yet dispensed
coin_count  output  4  coins issued in the current or last payout
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting sys_rst forces state=IDLE and coin_pulse=0, remaining=0, coin_count=0, busy=0, done=0.
  - Reset mid-payout takes effect immediately and clears any coin in progress.
- All outputs are registered. States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE, start=1 and abort=0, sampled at edge t:
  - remaining<=change_money, coin_count<=0.
  - Next state is SELECT if change_money!=0, else DONE.
- SELECT (exactly 1 cycle):
  - Picks d = the largest of {50,20,10,5,1} with d<=remaining.
  - Next edge: coin_pulse<=onehot(d), remaining<=remaining-d, coin_count<=coin_count+1, state<=PULSE.
  - The subtraction is 8-bit and never underflows, by construction.
- PULSE: coin_pulse held constant for exactly PULSE_CYCLES cycles, then coin_pulse<=0 and state<=GAP.
- GAP: lasts exactly GAP_CYCLES cycles, then goes to SELECT if remaining!=0, else DONE.
- DONE: done=1 for exactly 1 cycle, then IDLE.
  - remaining (=0) and coin_count keep their values until the next start.
- A single down-counter of >=23 bits serves both PULSE and GAP timing. It is reloaded on every state entry.
- Per-coin period is 1+PULSE_CYCLES+GAP_CYCLES cycles. Each coin's SELECT occurs 1+k*(1+PULSE_CYCLES+GAP_CYCLES) cycles after the start edge (k = coin index, 0-based).
- At most one coin_pulse bit is ever high; coin_pulse=0 outside PULSE.
- start while busy is ignored, including in DONE. change_money is sampled only at an accepted start.
- abort in any non-IDLE state:
  - Next edge: state<=IDLE, coin_pulse<=0, no done pulse.
  - remaining and coin_count are frozen, showing the undispensed amount.
- abort and start together in IDLE: abort wins and start is ignored. abort in IDLE alone has no effect.
- Maximum coin_count: 11 (for 249). A 4-bit counter has no wrap.

Test Plan:
- PULSE_CYCLES=2, GAP_CYCLES=1, change_money=37, start at t0:
  - coin_pulse sequence 0x08,0x04,0x02,0x01,0x01, each high 2 cycles, first at t2.
  - remaining goes 17,7,2,1,0.
  - done=1 only at t21, coin_count=5, busy low from t22.
- change_money=0, start -> DONE at t1 with done=1, no coin_pulse ever, coin_count=0, remaining=0.
- change_money=255 -> five 0x10 pulses then one 0x02 pulse, coin_count=6.
- change_money=249 -> 4x0x10, 2x0x08, 1x0x02, 4x0x01, coin_count=11.
- change_money=37, abort during the second coin's PULSE:
  - Next cycle coin_pulse=0, state IDLE, remaining=7, coin_count=2, done never asserted.
- Mid-payout start with change_money=99 is ignored and the original sequence continues unchanged.
- sys_rst pulsed mid-GAP asynchronously zeroes all outputs. A subsequent start=1 together with abort=1 in IDLE is ignored.
